// File: rtl/ifu_pkg.sv
// Shared types and constants for the way-0 instruction fetch stage.
package ifu_pkg;

  localparam int INST_W       = 32;
  localparam int FETCH_BYTES  = 8;
  localparam int FETCH_OFS_W  = $clog2(FETCH_BYTES);

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst0;
    logic [INST_W-1:0] inst1;
    logic [1:0]        mask;
    logic              err;
  } fetch_pkt_t;

  // An odd-word target starts at the upper slot, so slot 0 is not valid.
  function automatic logic [1:0] slot_mask(input logic odd_word);
    return {1'b1, ~odd_word};
  endfunction

endpackage

// File: rtl/ifu_fetch_way0_sync_fifo.sv
// Generic synchronous FIFO with async active-low reset and synchronous clear.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == DEPTH_CNT);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: it is only observed through a non-empty count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ifu_fetch_way0.sv
// Way-0 fetch stage: issues PC-unit addresses to imem, tracks in-flight tags,
// queues returned 64-bit packets for decode and discards responses killed by a flush.
module ifu_fetch_way0
  import ifu_pkg::*;
#(
  parameter int FQ_DEPTH        = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pc_valid_i,
  input  logic [31:0] pc_addr_i,
  output logic        pc_ready_o,
  input  logic        flush_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [63:0] imem_rdata_i,
  input  logic        imem_err_i,
  output logic        dec_valid_o,
  input  logic        dec_ready_i,
  output logic [31:0] dec_pc_o,
  output logic [31:0] dec_inst0_o,
  output logic [31:0] dec_inst1_o,
  output logic [1:0]  dec_mask_o,
  output logic        dec_err_o
);

  localparam int CNT_W    = $clog2(MAX_OUTSTANDING) + 1;
  localparam int FQ_CNT_W = $clog2(FQ_DEPTH) + 1;
  localparam int SUM_W    = ((CNT_W > FQ_CNT_W) ? CNT_W : FQ_CNT_W) + 2;

  logic [CNT_W-1:0]    outst_cnt;
  logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
  logic                alive_q, alive_d;
  logic [FQ_CNT_W-1:0] fq_count;
  logic [SUM_W-1:0]    inflight, occupancy;
  logic                credit_ok;
  logic                grant;
  logic                rsp_live, rsp_drop;
  logic                tag_pop;
  logic                tag_full, tag_empty;
  logic                fq_full, fq_empty, fq_pop;
  logic [31:0]         tag_head;
  fetch_pkt_t          fq_push_pkt, fq_head;

  // Dropped responses still occupy the memory pipeline, so they count against credit.
  assign inflight  = SUM_W'(outst_cnt) + SUM_W'(drop_cnt_q);
  assign occupancy = inflight + SUM_W'(fq_count);
  assign credit_ok = !tag_full && !fq_full
                  && (inflight < SUM_W'(MAX_OUTSTANDING))
                  && (occupancy < SUM_W'(FQ_DEPTH));

  assign imem_req_o  = alive_q && pc_valid_i && credit_ok && !flush_i;
  assign imem_addr_o = {pc_addr_i[31:FETCH_OFS_W], {FETCH_OFS_W{1'b0}}};
  assign grant       = imem_req_o && imem_gnt_i;
  assign pc_ready_o  = grant;

  assign rsp_live = imem_rvalid_i && (drop_cnt_q == '0);
  assign rsp_drop = imem_rvalid_i && (drop_cnt_q != '0);
  assign tag_pop  = rsp_live && !tag_empty;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear_i     (flush_i),
    .push_i      (grant),
    .push_data_i (pc_addr_i),
    .pop_i       (tag_pop),
    .pop_data_o  (tag_head),
    .full_o      (tag_full),
    .empty_o     (tag_empty),
    .count_o     (outst_cnt)
  );

  always_comb begin
    fq_push_pkt       = '0;
    fq_push_pkt.pc    = tag_head;
    fq_push_pkt.inst0 = imem_rdata_i[31:0];
    fq_push_pkt.inst1 = imem_rdata_i[63:32];
    fq_push_pkt.mask  = slot_mask(tag_head[2]);
    fq_push_pkt.err   = imem_err_i;
  end

  assign fq_pop = dec_valid_o && dec_ready_i;

  sync_fifo #(
    .WIDTH ($bits(fetch_pkt_t)),
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear_i     (flush_i),
    .push_i      (tag_pop),
    .push_data_i (fq_push_pkt),
    .pop_i       (fq_pop),
    .pop_data_o  (fq_head),
    .full_o      (fq_full),
    .empty_o     (fq_empty),
    .count_o     (fq_count)
  );

  assign dec_valid_o = !fq_empty;
  assign dec_pc_o    = dec_valid_o ? fq_head.pc    : '0;
  assign dec_inst0_o = dec_valid_o ? fq_head.inst0 : '0;
  assign dec_inst1_o = dec_valid_o ? fq_head.inst1 : '0;
  assign dec_mask_o  = dec_valid_o ? fq_head.mask  : '0;
  assign dec_err_o   = dec_valid_o && fq_head.err;

  // A flush converts everything still in flight into pending drops.
  always_comb begin
    alive_d    = 1'b1;
    drop_cnt_d = drop_cnt_q - CNT_W'(rsp_drop);
    if (flush_i) begin
      drop_cnt_d = outst_cnt - CNT_W'(rsp_live) + drop_cnt_q - CNT_W'(rsp_drop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt_q <= '0;
      alive_q    <= 1'b0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      alive_q    <= alive_d;
    end
  end

  a_rvalid_expected: assert property (@(posedge clk) disable iff (!reset_n)
    imem_rvalid_i |-> (outst_cnt != '0 || drop_cnt_q != '0));

  a_fq_has_room: assert property (@(posedge clk) disable iff (!reset_n)
    (rsp_live && !flush_i) |-> (!fq_full || fq_pop));

endmodule
